sram_boot_loader: RTL and testbench

- Boot-time sequencer for the core's instruction and data SRAMs.
- Accepts a byte stream (valid/ready, typically from a UART receiver) and parses write frames into 32-bit word writes to ISRAM or DSRAM.
- Holds the core in reset and owns both SRAM ports until a RUN command arrives, then hands the memories to the core.
- The top level uses mem_owner to mux SRAM ports between this block and the core.

---
 rtl/sram_boot_loader_pkg.sv | 30 +++
 rtl/sram_boot_loader_if.sv | 32 +++
 rtl/sram_boot_loader_timeout_ctr.sv | 33 +++
 rtl/sram_boot_loader.sv | 154 +++++++++++++++
 tb/tb_sram_boot_loader.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_boot_loader_pkg.sv
// Shared types and constants for the SRAM boot loader.
//   state_e         : loader FSM states
//   CMD_*_DEF       : default command byte values
//   FRAME_HDR_BYTES : CMD + ADDR_LO + ADDR_HI + LEN_LO + LEN_HI
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR0 = 3'd1,
        ADDR1 = 3'd2,
        LEN0  = 3'd3,
        LEN1  = 3'd4,
        DATA  = 3'd5,
        WRITE = 3'd6,
        RUN   = 3'd7
    } state_e;

    localparam logic [7:0] CMD_IWR_DEF = 8'hA5;
    localparam logic [7:0] CMD_DWR_DEF = 8'h5A;
    localparam logic [7:0] CMD_RUN_DEF = 8'hC3;

    localparam int FRAME_HDR_BYTES = 5;

    // States in which the inter-byte idle timer runs.
    function automatic logic in_frame(state_e s);
        return (s == ADDR0) || (s == ADDR1) || (s == LEN0) ||
               (s == LEN1)  || (s == DATA);
    endfunction

endpackage

// File: rtl/sram_boot_loader_if.sv
// Bus bundle between the boot loader and its surroundings.
//   in_valid/in_data/in_ready : byte stream (valid/ready)
//   mem_owner, cpu_nrst       : SRAM port ownership and core reset
//   isram_* / dsram_*         : SRAM write ports
//   err                       : sticky error flag
// master: byte source / system side.  slave: the loader.
interface sram_boot_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_owner;
    logic        cpu_nrst;
    logic        isram_wen;
    logic [15:0] isram_waddr;
    logic [31:0] isram_wdata;
    logic [3:0]  dsram_wen;
    logic [15:0] dsram_waddr;
    logic [31:0] dsram_wdata;
    logic        err;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_owner, cpu_nrst, isram_wen, isram_waddr, isram_wdata,
               dsram_wen, dsram_waddr, dsram_wdata, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_owner, cpu_nrst, isram_wen, isram_waddr, isram_wdata,
               dsram_wen, dsram_waddr, dsram_wdata, err
    );
endinterface

// File: rtl/sram_boot_loader_timeout_ctr.sv
// Inter-byte idle timer.  Down-counter reloaded whenever it is cleared or
// disabled; expire fires on the TIMEOUT-th consecutive enabled cycle with no
// clear.
//   clk, nrst : clock, synchronous active-high reset
//   clr       : restart the idle interval (byte accepted)
//   en        : timer running
//   expire    : idle interval elapsed this cycle
module boot_timeout_ctr #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic nrst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (nrst) begin
            cnt <= LOAD;
        end else if (clr || !en) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && !clr && (cnt == '0);
endmodule

// File: rtl/sram_boot_loader.sv
// Boot-time loader: parses write frames from a byte stream into 32-bit word
// writes to ISRAM/DSRAM, holding the core in reset until a RUN command.
//   clk, nrst : clock, synchronous active-high reset
//   bus       : slave side of sram_boot_loader_if (stream in, SRAM ports,
//               mem_owner, cpu_nrst, err)
//
// state | meaning
// IDLE  | waiting for a command byte
// ADDR0 | waiting for address low byte
// ADDR1 | waiting for address high byte
// LEN0  | waiting for word count low byte
// LEN1  | waiting for word count high byte
// DATA  | collecting the 4 bytes of a word
// WRITE | one-cycle write strobe, stream stalled
// RUN   | core released, loader idle until reset
module sram_boot_loader #(
    parameter logic [7:0] CMD_IWR = boot_pkg::CMD_IWR_DEF,
    parameter logic [7:0] CMD_DWR = boot_pkg::CMD_DWR_DEF,
    parameter logic [7:0] CMD_RUN = boot_pkg::CMD_RUN_DEF,
    parameter int         TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                nrst,
    sram_boot_loader_if.slave   bus
);
    import boot_pkg::*;

    state_e      state, state_nxt;
    logic        tgt_dsram;
    logic [15:0] addr;
    logic [15:0] len;
    logic [31:0] word;
    logic [1:0]  byte_idx;
    logic        out_en;
    logic        expire;
    logic        accept;
    logic        ready_c;
    logic [15:0] isram_waddr_q, dsram_waddr_q;
    logic [31:0] isram_wdata_q, dsram_wdata_q;
    logic [31:0] word_nxt;
    logic        err_q;

    assign accept   = bus.in_valid && ready_c;
    // Little-endian: each new byte enters at the top, so the first byte ends up in [7:0].
    assign word_nxt = {bus.in_data, word[31:8]};

    boot_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .nrst   (nrst),
        .clr    (accept),
        .en     (in_frame(state)),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (nrst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data == CMD_IWR || bus.in_data == CMD_DWR) state_nxt = ADDR0;
                    else if (bus.in_data == CMD_RUN)                      state_nxt = RUN;
                end
            end
            ADDR0: if (accept) state_nxt = ADDR1; else if (expire) state_nxt = IDLE;
            ADDR1: if (accept) state_nxt = LEN0;  else if (expire) state_nxt = IDLE;
            LEN0:  if (accept) state_nxt = LEN1;  else if (expire) state_nxt = IDLE;
            LEN1: begin
                if (accept) state_nxt = ({bus.in_data, len[7:0]} == 16'd0) ? IDLE : DATA;
                else if (expire) state_nxt = IDLE;
            end
            DATA: begin
                if (accept && byte_idx == 2'd3) state_nxt = WRITE;
                else if (!accept && expire)     state_nxt = IDLE;
            end
            WRITE:   state_nxt = (len == 16'd1) ? IDLE : DATA;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_c       = out_en && (state != WRITE) && (state != RUN);
        bus.in_ready  = ready_c;
        bus.mem_owner = (state != RUN);
        bus.cpu_nrst  = (state == RUN);
        bus.isram_wen = (state == WRITE) && !tgt_dsram;
        bus.dsram_wen = ((state == WRITE) && tgt_dsram) ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            out_en        <= 1'b0;
            tgt_dsram     <= 1'b0;
            addr          <= '0;
            len           <= '0;
            word          <= '0;
            byte_idx      <= '0;
            err_q         <= 1'b0;
            isram_waddr_q <= '0;
            isram_wdata_q <= '0;
            dsram_waddr_q <= '0;
            dsram_wdata_q <= '0;
        end else begin
            out_en <= 1'b1;
            if (accept) begin
                case (state)
                    IDLE: begin
                        if (bus.in_data == CMD_IWR)      tgt_dsram <= 1'b0;
                        else if (bus.in_data == CMD_DWR) tgt_dsram <= 1'b1;
                        else if (bus.in_data != CMD_RUN) err_q     <= 1'b1;
                    end
                    ADDR0: addr[7:0]  <= {bus.in_data[7:2], 2'b00};
                    ADDR1: addr[15:8] <= bus.in_data;
                    LEN0:  len[7:0]   <= bus.in_data;
                    LEN1: begin
                        len[15:8] <= bus.in_data;
                        byte_idx  <= 2'd0;
                    end
                    DATA: begin
                        word     <= word_nxt;
                        byte_idx <= byte_idx + 2'd1;
                        // Output registers load on entry to WRITE and then hold.
                        if (byte_idx == 2'd3) begin
                            if (tgt_dsram) begin
                                dsram_waddr_q <= addr;
                                dsram_wdata_q <= word_nxt;
                            end else begin
                                isram_waddr_q <= addr;
                                isram_wdata_q <= word_nxt;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            if (expire) err_q <= 1'b1;
            if (state == WRITE) begin
                addr <= addr + 16'd4;
                len  <= len - 16'd1;
            end
        end
    end

    assign bus.isram_waddr = isram_waddr_q;
    assign bus.isram_wdata = isram_wdata_q;
    assign bus.dsram_waddr = dsram_waddr_q;
    assign bus.dsram_wdata = dsram_wdata_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_sram_boot_loader.sv
// Self-checking bench for sram_boot_loader: a byte-level frame model predicts
// every output each cycle; directed frames pin the model with literal values.
module tb_sram_boot_loader;
    import boot_pkg::*;

    localparam int TMO = 32;

    logic clk = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    sram_boot_loader_if bus();

    sram_boot_loader #(.TIMEOUT(TMO)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        d;
        logic [15:0] a;
        logic [31:0] w;
    } wr_t;

    wr_t m_log[$];
    wr_t d_log[$];
    int  d_cyc[$];

    // ---------------- behavioural model ----------------
    bit        m_en, m_run, m_infr, m_wr, m_tgt_d, m_err;
    int        m_hdr, m_nb, m_idle;
    bit [15:0] m_addr, m_len, m_ia, m_da;
    bit [31:0] m_word, m_id, m_dd;

    always @(posedge clk) begin
        bit       acc;
        bit [7:0] b;
        cyc++;
        if (nrst) begin
            m_en = 0; m_run = 0; m_infr = 0; m_wr = 0; m_tgt_d = 0; m_err = 0;
            m_hdr = 0; m_nb = 0; m_idle = 0;
            m_addr = 0; m_len = 0; m_word = 0;
            m_ia = 0; m_da = 0; m_id = 0; m_dd = 0;
        end else begin
            acc  = bus.in_valid && m_en && !m_run && !m_wr;
            b    = bus.in_data;
            m_en = 1;
            if (m_wr) begin
                m_wr   = 0;
                m_addr = m_addr + 16'd4;
                m_len  = m_len - 16'd1;
                m_idle = 0;
                if (m_len == 0) m_infr = 0;
            end else if (m_run) begin
                // terminal
            end else if (!m_infr) begin
                if (acc) begin
                    if (b == 8'hA5 || b == 8'h5A) begin
                        m_infr = 1; m_tgt_d = (b == 8'h5A); m_hdr = 0; m_idle = 0;
                    end else if (b == 8'hC3) begin
                        m_run = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (acc) begin
                m_idle = 0;
                if (m_hdr < FRAME_HDR_BYTES - 1) begin
                    case (m_hdr)
                        0: m_addr[7:0]  = b & 8'hFC;
                        1: m_addr[15:8] = b;
                        2: m_len[7:0]   = b;
                        default: begin
                            m_len[15:8] = b;
                            m_nb = 0;
                            if (m_len == 0) m_infr = 0;
                        end
                    endcase
                    m_hdr++;
                end else begin
                    m_word[8*m_nb +: 8] = b;
                    m_nb++;
                    if (m_nb == 4) begin
                        m_nb = 0;
                        m_wr = 1;
                        if (m_tgt_d) begin m_da = m_addr; m_dd = m_word; end
                        else         begin m_ia = m_addr; m_id = m_word; end
                        m_log.push_back({m_tgt_d, m_addr, m_word});
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_err  = 1;
                    m_infr = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare and write monitor ----------------
    always @(negedge clk) begin
        check("in_ready",    bus.in_ready,    m_en && !m_run && !m_wr);
        check("mem_owner",   bus.mem_owner,   !m_run);
        check("cpu_nrst",    bus.cpu_nrst,    m_run);
        check("isram_wen",   bus.isram_wen,   m_wr && !m_tgt_d);
        check("dsram_wen",   bus.dsram_wen,   (m_wr && m_tgt_d) ? 4'hF : 4'h0);
        check("err",         bus.err,         m_err);
        check("isram_waddr", bus.isram_waddr, m_ia);
        check("isram_wdata", bus.isram_wdata, m_id);
        check("dsram_waddr", bus.dsram_waddr, m_da);
        check("dsram_wdata", bus.dsram_wdata, m_dd);
        if (bus.isram_wen) begin
            d_log.push_back({1'b0, bus.isram_waddr, bus.isram_wdata});
            d_cyc.push_back(cyc);
        end
        if (bus.dsram_wen != 4'h0) begin
            d_log.push_back({1'b1, bus.dsram_waddr, bus.dsram_wdata});
            d_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers (called at negedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: in_ready stuck at 0 for byte %0h", b);
        end else begin
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic chk_wr(input string nm, input int di, input int mi,
                          input logic d, input logic [15:0] a, input logic [31:0] w);
        check({nm, "_dut_present"}, d_log.size() > di, 1'b1);
        if (d_log.size() > di) check({nm, "_dut"}, d_log[di], {d, a, w});
        check({nm, "_model_present"}, m_log.size() > mi, 1'b1);
        if (m_log.size() > mi) check({nm, "_model"}, m_log[mi], {d, a, w});
    endtask

    task automatic pulse_reset(input int n);
        nrst = 1'b1;
        idle(n);
        nrst = 1'b0;
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] b = 8'($urandom);
        if (b == 8'hC3) b = 8'hC2;
        return b;
    endfunction

    initial begin
        int db, mb, gap, len, r;
        logic [7:0] q[$];
        logic [7:0] g;
        logic [15:0] a;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        nrst = 1'b1;
        idle(3);
        check("rst_in_ready",  bus.in_ready,  1'b0);
        check("rst_mem_owner", bus.mem_owner, 1'b1);
        check("rst_cpu_nrst",  bus.cpu_nrst,  1'b0);
        check("rst_err",       bus.err,       1'b0);
        check("rst_dsram_wen", bus.dsram_wen, 4'h0);
        nrst = 1'b0;
        idle(1);
        check("ready_after_rst", bus.in_ready, 1'b1);

        // single ISRAM word
        db = d_log.size(); mb = m_log.size();
        q = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_bytes(q);
        idle(2);
        check("t1_count", d_log.size() - db, 1);
        chk_wr("t1_w0", db, mb, 1'b0, 16'h0100, 32'h12345678);
        check("t1_err", bus.err, 1'b0);

        // DSRAM two words, address LSBs masked, back-to-back
        db = d_log.size(); mb = m_log.size();
        q = '{8'h5A, 8'h03, 8'h02, 8'h02, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_bytes(q);
        idle(2);
        check("t2_count", d_log.size() - db, 2);
        chk_wr("t2_w0", db,     mb,     1'b1, 16'h0200, 32'h44332211);
        chk_wr("t2_w1", db + 1, mb + 1, 1'b1, 16'h0204, 32'h88776655);
        if (d_cyc.size() > db + 1) check("t2_spacing", d_cyc[db+1] - d_cyc[db], 5);

        // address wrap
        db = d_log.size(); mb = m_log.size();
        q = '{8'hA5, 8'hFC, 8'hFF, 8'h02, 8'h00,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_bytes(q);
        idle(2);
        chk_wr("t3_w0", db,     mb,     1'b0, 16'hFFFC, 32'h04030201);
        chk_wr("t3_w1", db + 1, mb + 1, 1'b0, 16'h0000, 32'h08070605);

        // bad command, then a good frame
        db = d_log.size(); mb = m_log.size();
        send_byte(8'h77);
        idle(1);
        check("t4_err", bus.err, 1'b1);
        check("t4_nowrite", d_log.size() - db, 0);
        q = '{8'hA5, 8'h10, 8'h00, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_bytes(q);
        idle(2);
        chk_wr("t4_w0", db, mb, 1'b0, 16'h0010, 32'hEFBEADDE);

        // timeout mid-word
        pulse_reset(1);
        idle(1);
        check("t5_err_cleared", bus.err, 1'b0);
        db = d_log.size(); mb = m_log.size();
        q = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
        send_bytes(q);
        idle(TMO - 1);
        check("t5_err_before_tmo", bus.err, 1'b0);
        idle(1);
        check("t5_err_at_tmo", bus.err, 1'b1);
        check("t5_nowrite", d_log.size() - db, 0);
        q = '{8'hA5, 8'h20, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_bytes(q);
        idle(2);
        chk_wr("t5_w0", db, mb, 1'b0, 16'h0020, 32'hDDCCBBAA);

        // RUN then reset
        send_byte(8'hC3);
        check("t6_cpu_nrst",  bus.cpu_nrst,  1'b1);
        check("t6_mem_owner", bus.mem_owner, 1'b0);
        check("t6_in_ready",  bus.in_ready,  1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        idle(3);
        check("t6_run_held", bus.in_ready, 1'b0);
        bus.in_valid = 1'b0;
        nrst = 1'b1;
        idle(1);
        nrst = 1'b0;
        check("t6_rst_cpu_nrst",  bus.cpu_nrst,  1'b0);
        check("t6_rst_mem_owner", bus.mem_owner, 1'b1);
        check("t6_rst_in_ready",  bus.in_ready,  1'b0);
        idle(1);
        check("t6_ready_after", bus.in_ready, 1'b1);

        // randomized traffic
        for (int f = 0; f < 250; f++) begin
            r = $urandom_range(0, 99);
            if (r < 5) begin
                pulse_reset($urandom_range(1, 2));
            end else if (r < 10) begin
                g = 8'($urandom);
                if (g == 8'hA5 || g == 8'h5A || g == 8'hC3) g = 8'h00;
                send_byte(g);
            end else if (r < 12) begin
                send_byte(8'hC3);
                idle(2);
                pulse_reset(1);
            end else begin
                a   = 16'($urandom);
                len = $urandom_range(0, 3);
                q = '{($urandom_range(0, 1) != 0) ? 8'hA5 : 8'h5A, a[7:0], a[15:8],
                      8'(len), 8'h00};
                for (int i = 0; i < 4 * len; i++) q.push_back(rnd_byte());
                foreach (q[i]) begin
                    send_byte(q[i]);
                    gap = ($urandom_range(0, 39) == 0) ? (TMO - 2 + $urandom_range(0, 3))
                                                       : $urandom_range(0, 2);
                    idle(gap);
                end
            end
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
